tri_host_driver: RTL and testbench
==================================

# tri_host_driver

Host-side issuer for the triangle rendering engine: it accepts one triangle (three vertices) per request from an upstream sequencer or bench, plays it onto the engine's `nt`/`xi`/`yi` input port in the three-cycle vertex order the engine's controller samples, then watches `busy`/`po` until rendering completes. It reports the number of pixels emitted and flags a hung engine via a timeout.

## Interface
- `COORD_W`, 3: width of each vertex coordinate and of `xi`/`yi`.
- `CNT_W`, 7: pixel counter width; counter saturates.
- `TIMEOUT`, 255: maximum WAIT-state cycles before abort; minimum 4.
- `TO_W`, 8: timeout counter width; must satisfy TIMEOUT < 2^TO_W.

Ports:
- `clk`  in  1  sole clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `req_valid`  in  1  triangle request present.
- `req_ready`  out  1  request accepted this cycle.
- `req_tri`  in  6*COORD_W  {x1,y1,x2,y2,x3,y3}, x1 in the MSBs.
- `nt`  out  1  new-triangle strobe to engine.
- `xi`, `yi`  out  COORD_W each  vertex coordinates to engine.
- `busy`  in  1  engine busy.
- `po`  in  1  engine pixel-valid strobe.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  one-cycle timeout pulse, coincident with `done`.
- `pix_cnt`  out  CNT_W  pixels seen for the last triangle; held until the next acceptance.

## Operation
- States: IDLE, V1, V2, V3, WAIT, DONE.
- IDLE: `req_ready` = (state==IDLE) & !busy & rst. Acceptance = `req_valid` & `req_ready`. On acceptance, latch `req_tri` into an internal register, clear `pix_cnt` and the timeout counter, and go to V1.
- V1: `nt`=1, `xi`/`yi`=x1/y1. Go to V2.
- V2: `nt`=0, `xi`/`yi`=x2/y2. Go to V3.
- V3: `xi`/`yi`=x3/y3. Go to WAIT.
- WAIT: `xi`/`yi` hold x3/y3. Each cycle, increment the timeout counter.
  - If `busy`==0, go to DONE.
  - Else if the counter reaches TIMEOUT, set the internal err flag and go to DONE.
- DONE: `done`=1. `err`=1 if the timeout fired. Go to IDLE.
- Pixel counting: in V2, V3 and WAIT, each cycle with `po`=1 increments `pix_cnt`. It saturates at 2^CNT_W-1. `po` in any other state is ignored.
- Busy check: in WAIT, `busy` is sampled only from the second WAIT cycle onward. A `busy`=0 on the first WAIT cycle is treated as the engine not yet started, and the block stays in WAIT.
- Request latching: `req_tri` changes after acceptance have no effect on the triangle in flight.
- No acceptance in V1..DONE. A held `req_valid` is accepted in the first IDLE cycle with `busy`=0, so back-to-back triangles are spaced DONE→IDLE→V1.

## Timing
- Reset (`rst`=0 at a clock edge):
  - state→IDLE.
  - `nt`=0, `xi`=`yi`=0, `done`=0, `err`=0, `pix_cnt`=0.
  - `req_ready`=0 while `rst` is low.
  - Reset mid-triangle aborts immediately. There is no `done` pulse, and `nt` is never left high.
- `nt`, `xi`, `yi`, `done`, `err` are registered; they change only on clock edges.
- Latency: acceptance at edge T, then `nt`=1 in cycle T+1 with v1, v2 in T+2, v3 in T+3.
- Minimum acceptance-to-`done` time is 6 cycles: the engine deasserts `busy` at the second WAIT cycle, and `done` follows one cycle later.
- `err` path: `done`/`err` are asserted TIMEOUT+1 cycles after WAIT entry.
- `pix_cnt` is stable from the `done` cycle until the next acceptance.
- Simultaneous `po`=1 and `busy` falling in WAIT: the pixel is counted.
- `po`=1 in DONE is not counted.

## Test plan
- Single triangle (0,0),(7,0),(0,7); engine model emits 36 `po` pulses → `nt` high exactly one cycle with xi/yi=0/0, then 7/0, then 0/7. `done` fires once, `pix_cnt`=36, `err`=0.
- `req_valid` held with `busy`=1 for 10 cycles → `req_ready`=0 and `nt`=0 throughout. Acceptance occurs on the first cycle with `busy`=0, and `nt` rises on the next cycle.
- Two queued triangles back-to-back → second `nt` exactly 2 cycles after the first `done`. `pix_cnt` resets to 0 at the second acceptance. Changing `req_tri` during V2 does not alter v3 on `xi`/`yi`.
- Engine model holds `busy`=1 forever, TIMEOUT=20 → `done`=`err`=1 together 21 cycles after WAIT entry, then the block returns to IDLE.
- `rst`=0 asserted during V2, then released → next cycle shows `nt`=0, `xi`=`yi`=0, `pix_cnt`=0, and no `done`. A new request is then accepted normally.
- CNT_W=3 with 10 `po` pulses → `pix_cnt`=7 (saturated), `done` normal, `err`=0.

Source files
------------

// File: rtl/tri_host_driver.sv
// Host-side issuer for the triangle rendering engine: plays one triangle onto
// nt/xi/yi in vertex order, then tracks busy/po for completion, pixel count and timeout.
module tri_host_driver #(
  parameter int unsigned COORD_W = 3,
  parameter int unsigned CNT_W   = 7,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TO_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [6*COORD_W-1:0] req_tri,
  output logic                 nt,
  output logic [COORD_W-1:0]   xi,
  output logic [COORD_W-1:0]   yi,
  input  logic                 busy,
  input  logic                 po,
  output logic                 done,
  output logic                 err,
  output logic [CNT_W-1:0]     pix_cnt
);

  typedef struct packed {
    logic [COORD_W-1:0] x1;
    logic [COORD_W-1:0] y1;
    logic [COORD_W-1:0] x2;
    logic [COORD_W-1:0] y2;
    logic [COORD_W-1:0] x3;
    logic [COORD_W-1:0] y3;
  } tri_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_V1,
    S_V2,
    S_V3,
    S_WAIT,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  tri_t               tri_q, tri_d;
  logic [TO_W-1:0]    to_q, to_d;
  logic [CNT_W-1:0]   pix_q, pix_d;
  logic               nt_d, done_d, err_d;
  logic [COORD_W-1:0] xi_d, yi_d;
  logic               accept;
  logic               counting;

  // Ready only when idle, engine quiet and out of reset.
  assign req_ready = (state_q == S_IDLE) && !busy && rst;
  assign pix_cnt   = pix_q;

  // Next-state, datapath and next-output logic.
  always_comb begin
    state_d  = state_q;
    tri_d    = tri_q;
    to_d     = to_q;
    pix_d    = pix_q;
    nt_d     = 1'b0;
    xi_d     = xi;
    yi_d     = yi;
    done_d   = 1'b0;
    err_d    = 1'b0;
    accept   = req_valid && req_ready;
    counting = (state_q == S_V2) || (state_q == S_V3) || (state_q == S_WAIT);

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          tri_d   = tri_t'(req_tri);
          to_d    = '0;
          pix_d   = '0;
          state_d = S_V1;
        end
      end
      S_V1:   state_d = S_V2;
      S_V2:   state_d = S_V3;
      S_V3:   state_d = S_WAIT;
      S_WAIT: begin
        to_d = to_q + TO_W'(1);
        // First WAIT cycle (to_q == 0) ignores busy: engine may not have started yet.
        if ((to_q != '0) && !busy) begin
          state_d = S_DONE;
        end else if (to_q == TO_W'(TIMEOUT)) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (counting && po && (pix_q != {CNT_W{1'b1}})) begin
      pix_d = pix_q + CNT_W'(1);
    end

    // Outputs are registered from the next state so they line up with it.
    case (state_d)
      S_V1: begin
        nt_d = 1'b1;
        xi_d = tri_d.x1;
        yi_d = tri_d.y1;
      end
      S_V2: begin
        xi_d = tri_d.x2;
        yi_d = tri_d.y2;
      end
      S_V3: begin
        xi_d = tri_d.x3;
        yi_d = tri_d.y3;
      end
      S_DONE:  done_d = 1'b1;
      default: ;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      tri_q   <= '0;
      to_q    <= '0;
      pix_q   <= '0;
      nt      <= 1'b0;
      xi      <= '0;
      yi      <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      tri_q   <= tri_d;
      to_q    <= to_d;
      pix_q   <= pix_d;
      nt      <= nt_d;
      xi      <= xi_d;
      yi      <= yi_d;
      done    <= done_d;
      err     <= err_d;
    end
  end

endmodule

// File: tb/tb_tri_host_driver.sv
// Self-checking bench for tri_host_driver: three instances (default, short
// timeout, narrow counter) share stimulus and are checked against a cycle-index model.
module tb_tri_host_driver;

  localparam int unsigned CW    = 3;
  localparam int          TO_A  = 255;
  localparam int          TO_T  = 20;

  logic          clk, rst, req_valid, busy, po;
  logic [6*CW-1:0] req_tri;

  logic          rdy_a, nt_a, done_a, err_a;
  logic [CW-1:0] xi_a, yi_a;
  logic [6:0]    pix_a;
  logic          rdy_t, nt_t, done_t, err_t;
  logic [CW-1:0] xi_t, yi_t;
  logic [6:0]    pix_t;
  logic          rdy_s, nt_s, done_s, err_s;
  logic [CW-1:0] xi_s, yi_s;
  logic [2:0]    pix_s;

  int errors = 0;
  int checks = 0;

  tri_host_driver #(.COORD_W(3), .CNT_W(7), .TIMEOUT(TO_A), .TO_W(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy_a), .req_tri(req_tri),
    .nt(nt_a), .xi(xi_a), .yi(yi_a), .busy(busy), .po(po),
    .done(done_a), .err(err_a), .pix_cnt(pix_a));

  tri_host_driver #(.COORD_W(3), .CNT_W(7), .TIMEOUT(TO_T), .TO_W(5)) dut_t (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy_t), .req_tri(req_tri),
    .nt(nt_t), .xi(xi_t), .yi(yi_t), .busy(busy), .po(po),
    .done(done_t), .err(err_t), .pix_cnt(pix_t));

  tri_host_driver #(.COORD_W(3), .CNT_W(3), .TIMEOUT(TO_A), .TO_W(8)) dut_s (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy_s), .req_tri(req_tri),
    .nt(nt_s), .xi(xi_s), .yi(yi_s), .busy(busy), .po(po),
    .done(done_s), .err(err_s), .pix_cnt(pix_s));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // First WAIT index (counted from 0) at which the engine is seen idle.
  function automatic int first_idle_j(input int l);
    return (l - 2 < 1) ? 1 : l - 2;
  endfunction

  function automatic int sat(input int v, input int w);
    int m;
    m = (1 << w) - 1;
    return (v > m) ? m : v;
  endfunction

  // One triangle. Cycle 0 is the acceptance cycle, cycle 1 shows v1.
  // Engine holds busy in cycles 2..l+1; po random (prob% while busy, stray% otherwise).
  task automatic run_tri(input logic [17:0] t, input int l, input int pre_busy,
                         input int prob, input int stray,
                         output int pix_main, output int pix_small);
    bit bz [0:127];
    bit pz [0:127];
    logic [2:0] ex [1:3];
    logic [2:0] ey [1:3];
    logic [2:0] exx, eyy;
    int jf, ja, jt, dca, dct, end_c, min_d, cnt_a, cnt_t;
    bit erra, errt, e_nt, e_rdy_a, e_rdy_t;
    ex[1] = t[17:15]; ey[1] = t[14:12];
    ex[2] = t[11:9];  ey[2] = t[8:6];
    ex[3] = t[5:3];   ey[3] = t[2:0];
    jf   = first_idle_j(l);
    ja   = (jf > TO_A) ? TO_A : jf;
    erra = (jf > TO_A);
    jt   = (jf > TO_T) ? TO_T : jf;
    errt = (jf > TO_T);
    dca  = 5 + ja;
    dct  = 5 + jt;
    end_c = (dca > dct) ? dca : dct;
    min_d = (dca < dct) ? dca : dct;
    for (int c = 0; c < 128; c++) begin
      bz[c] = (c >= 2) && (c <= l + 1);
      pz[c] = bz[c] ? (int'($urandom_range(0, 99)) < prob) : (int'($urandom_range(0, 99)) < stray);
    end
    cnt_a = 0;
    cnt_t = 0;
    for (int c = 2; c <= 4 + ja; c++) cnt_a += int'(pz[c]);
    for (int c = 2; c <= 4 + jt; c++) cnt_t += int'(pz[c]);
    pix_main  = -1;
    pix_small = -1;

    for (int k = 0; k < pre_busy; k++) begin
      req_valid = 1'b1; req_tri = t; busy = 1'b1; po = 1'($urandom_range(0, 1));
      @(negedge clk);
      checks++;
      if (rdy_a !== 1'b0 || nt_a !== 1'b0 || rdy_t !== 1'b0)
        begin errors++; $display("FAIL hold k=%0d rdy=%b nt=%b rdy_t=%b expected 0 0 0", k, rdy_a, nt_a, rdy_t); end
      @(posedge clk); #1;
    end

    req_valid = 1'b1; req_tri = t; busy = 1'b0; po = 1'($urandom_range(0, 1));
    @(negedge clk);
    checks++;
    if (rdy_a !== 1'b1 || rdy_t !== 1'b1 || rdy_s !== 1'b1)
      begin errors++; $display("FAIL accept rdy=%b/%b/%b expected 1/1/1", rdy_a, rdy_t, rdy_s); end
    @(posedge clk); #1;

    for (int c = 1; c <= end_c; c++) begin
      req_valid = (c <= min_d) ? 1'($urandom_range(0, 1)) : 1'b0;
      req_tri   = 18'($urandom);
      busy      = bz[c];
      po        = pz[c];
      @(negedge clk);
      e_nt    = (c == 1);
      exx     = ex[(c > 3) ? 3 : c];
      eyy     = ey[(c > 3) ? 3 : c];
      e_rdy_a = (c > dca) && !bz[c];
      e_rdy_t = (c > dct) && !bz[c];
      checks++;
      if (nt_a !== e_nt || nt_t !== e_nt || nt_s !== e_nt)
        begin errors++; $display("FAIL nt c=%0d got %b/%b/%b expected %b", c, nt_a, nt_t, nt_s, e_nt); end
      if (c <= 4 + ja) begin
        checks++;
        if (xi_a !== exx || yi_a !== eyy || xi_s !== exx || yi_s !== eyy)
          begin errors++; $display("FAIL vertex c=%0d got %0d,%0d expected %0d,%0d", c, xi_a, yi_a, exx, eyy); end
      end
      if (c <= 4 + jt) begin
        checks++;
        if (xi_t !== exx || yi_t !== eyy)
          begin errors++; $display("FAIL vertex_t c=%0d got %0d,%0d expected %0d,%0d", c, xi_t, yi_t, exx, eyy); end
      end
      checks++;
      if (done_a !== (c == dca) || err_a !== ((c == dca) && erra) || rdy_a !== e_rdy_a ||
          done_s !== (c == dca) || err_s !== ((c == dca) && erra) || rdy_s !== e_rdy_a)
        begin errors++; $display("FAIL ctrl c=%0d done=%b err=%b rdy=%b expected %b %b %b",
                                 c, done_a, err_a, rdy_a, (c == dca), ((c == dca) && erra), e_rdy_a); end
      checks++;
      if (done_t !== (c == dct) || err_t !== ((c == dct) && errt) || rdy_t !== e_rdy_t)
        begin errors++; $display("FAIL ctrl_t c=%0d done=%b err=%b rdy=%b expected %b %b %b",
                                 c, done_t, err_t, rdy_t, (c == dct), ((c == dct) && errt), e_rdy_t); end
      if (c == 1) begin
        checks++;
        if (pix_a !== 7'd0 || pix_t !== 7'd0 || pix_s !== 3'd0)
          begin errors++; $display("FAIL pix_clear got %0d/%0d/%0d expected 0", pix_a, pix_t, pix_s); end
      end
      if (c >= dca) begin
        checks++;
        if (pix_a !== 7'(sat(cnt_a, 7)) || pix_s !== 3'(sat(cnt_a, 3)))
          begin errors++; $display("FAIL pix c=%0d got %0d/%0d expected %0d/%0d",
                                   c, pix_a, pix_s, sat(cnt_a, 7), sat(cnt_a, 3)); end
        if (c == dca) begin
          pix_main  = int'(pix_a);
          pix_small = int'(pix_s);
        end
      end
      if (c >= dct) begin
        checks++;
        if (pix_t !== 7'(sat(cnt_t, 7)))
          begin errors++; $display("FAIL pix_t c=%0d got %0d expected %0d", c, pix_t, sat(cnt_t, 7)); end
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    busy      = 1'b0;
    po        = 1'b0;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      rst = 1'b0; req_valid = 1'b1; busy = 1'b0; po = 1'b1; req_tri = 18'($urandom);
      @(negedge clk);
      checks++;
      if (rdy_a !== 1'b0 || nt_a !== 1'b0 || xi_a !== 3'd0 || yi_a !== 3'd0 ||
          done_a !== 1'b0 || err_a !== 1'b0 || pix_a !== 7'd0 || rdy_t !== 1'b0)
        begin errors++; $display("FAIL reset k=%0d rdy=%b nt=%b xi=%0d yi=%0d done=%b err=%b pix=%0d expected all 0",
                                 k, rdy_a, nt_a, xi_a, yi_a, done_a, err_a, pix_a); end
      @(posedge clk); #1;
    end
    rst = 1'b1; req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (rdy_a !== 1'b1 || nt_a !== 1'b0)
      begin errors++; $display("FAIL reset_release rdy=%b nt=%b expected 1 0", rdy_a, nt_a); end
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    int pm, ps;
    run_tri({3'd0, 3'd0, 3'd7, 3'd0, 3'd0, 3'd7}, 36, 0, 100, 0, pm, ps);
    checks++;
    if (pm != 36) begin errors++; $display("FAIL single_pix got %0d expected 36", pm); end
  endtask

  task automatic test_min_latency();
    int pm, ps;
    run_tri(18'($urandom), 0, 0, 50, 50, pm, ps);
    run_tri(18'($urandom), 3, 0, 50, 50, pm, ps);
    run_tri(18'($urandom), 4, 0, 50, 50, pm, ps);
  endtask

  task automatic test_busy_hold();
    int pm, ps;
    run_tri(18'($urandom), 12, 10, 70, 30, pm, ps);
  endtask

  task automatic test_back_to_back();
    int pm, ps;
    run_tri(18'($urandom), 8, 0, 100, 0, pm, ps);
    run_tri(18'($urandom), 9, 0, 60, 40, pm, ps);
  endtask

  task automatic test_timeout();
    int pm, ps;
    run_tri(18'($urandom), 60, 0, 50, 50, pm, ps);
  endtask

  task automatic test_reset_mid();
    logic [17:0] t;
    int pm, ps;
    t = 18'($urandom);
    req_valid = 1'b1; req_tri = t; busy = 1'b0; po = 1'b0;
    @(negedge clk); @(posedge clk); #1;
    req_valid = 1'b0; busy = 1'b1; po = 1'b1;
    @(negedge clk);
    checks++;
    if (nt_a !== 1'b1) begin errors++; $display("FAIL rmid_v1 nt=%b expected 1", nt_a); end
    @(posedge clk); #1;
    rst = 1'b0; busy = 1'b1; po = 1'b1;
    @(negedge clk);
    checks++;
    if (nt_a !== 1'b0 || xi_a !== t[11:9] || rdy_a !== 1'b0 || pix_a !== 7'd0)
      begin errors++; $display("FAIL rmid_v2 nt=%b xi=%0d rdy=%b pix=%0d expected 0 %0d 0 0",
                               nt_a, xi_a, rdy_a, pix_a, t[11:9]); end
    @(posedge clk); #1;
    rst = 1'b1; busy = 1'b0; po = 1'b0;
    @(negedge clk);
    checks++;
    if (nt_a !== 1'b0 || xi_a !== 3'd0 || yi_a !== 3'd0 || pix_a !== 7'd0 ||
        done_a !== 1'b0 || err_a !== 1'b0 || rdy_a !== 1'b1)
      begin errors++; $display("FAIL rmid_after nt=%b xi=%0d yi=%0d pix=%0d done=%b err=%b rdy=%b expected 0 0 0 0 0 0 1",
                               nt_a, xi_a, yi_a, pix_a, done_a, err_a, rdy_a); end
    @(posedge clk); #1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if (done_a !== 1'b0 || nt_a !== 1'b0 || done_t !== 1'b0)
        begin errors++; $display("FAIL rmid_quiet k=%0d done=%b nt=%b done_t=%b expected 0 0 0", k, done_a, nt_a, done_t); end
      @(posedge clk); #1;
    end
    run_tri(18'($urandom), 6, 0, 50, 50, pm, ps);
  endtask

  task automatic test_saturate();
    int pm, ps;
    run_tri(18'($urandom), 10, 0, 100, 0, pm, ps);
    checks++;
    if (pm != 10 || ps != 7) begin errors++; $display("FAIL saturate got %0d/%0d expected 10/7", pm, ps); end
  endtask

  task automatic test_random();
    int pm, ps;
    for (int i = 0; i < 8; i++) begin
      run_tri(18'($urandom), int'($urandom_range(0, 45)), int'($urandom_range(0, 3)), 60, 40, pm, ps);
    end
  endtask

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_tri = '0; busy = 1'b0; po = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_single();
    test_min_latency();
    test_busy_hold();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    test_saturate();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
